// File: rtl/sound_arbiter_if.sv
// Sound-effect request bus between effect requesters and the arbiter.
interface sound_arbiter_if #(
   parameter int unsigned N_SFX  = 4,
   parameter int unsigned FREQ_W = 26,
   parameter int unsigned LEN_W  = 8
);
   logic [N_SFX-1:0]        sfx_req;
   logic [N_SFX*FREQ_W-1:0] sfx_freq;
   logic [N_SFX*LEN_W-1:0]  sfx_len;
   logic [N_SFX-1:0]        sfx_ack;

   modport master (output sfx_req, output sfx_freq, output sfx_len, input sfx_ack);
   modport slave  (input sfx_req, input sfx_freq, input sfx_len, output sfx_ack);
endinterface

// File: rtl/sound_arbiter.sv
// Shares the note generator between background music and prioritized one-shot
// sound effects; effects are timed in prescaled ticks and followed by a silence gap.
module sound_arbiter #(
   parameter int unsigned N_SFX        = 4,
   parameter int unsigned FREQ_W       = 26,
   parameter int unsigned LEN_W        = 8,
   parameter int unsigned TICK_DIV     = 1000000,
   parameter int unsigned GAP_TICKS    = 2,
   parameter int unsigned SILENCE_FREQ = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mute,
   input  logic [FREQ_W-1:0] bgm_freqL,
   input  logic [FREQ_W-1:0] bgm_freqR,
   sound_arbiter_if.slave    sfx,
   output logic [FREQ_W-1:0] freqL,
   output logic [FREQ_W-1:0] freqR,
   output logic [1:0]        active_id,
   output logic              sfx_busy
);

   localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned GAP_W = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;
   localparam logic [FREQ_W-1:0] SILENCE = FREQ_W'(SILENCE_FREQ);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      GAP  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [N_SFX-1:0]   pending_q, pending_d;
   logic [PRE_W-1:0]   pre_q;
   logic [LEN_W-1:0]   dur_q, dur_d;
   logic [GAP_W-1:0]   gap_q, gap_d;
   logic [FREQ_W-1:0]  play_freq_q, play_freq_d;
   logic [N_SFX-1:0]   ack_d;
   logic [1:0]         id_d;
   logic [FREQ_W-1:0]  freq_l_d, freq_r_d;
   logic               tick;
   logic               any_pend;
   logic               grant;
   logic [1:0]         sel_idx;
   logic [N_SFX-1:0]   sel_oh;
   logic [LEN_W-1:0]   sel_len;
   logic [FREQ_W-1:0]  sel_freq;

   // Tick strobe on the last prescaler count.
   assign tick = (pre_q == PRE_W'(TICK_DIV - 1));

   // Free-running prescaler; grants never restart it.
   always_ff @(posedge clk) begin
      if (rst) begin
         pre_q <= '0;
      end else if (tick) begin
         pre_q <= '0;
      end else begin
         pre_q <= pre_q + PRE_W'(1);
      end
   end

   // Fixed-priority pick of the lowest pending index with its length and frequency.
   always_comb begin
      sel_idx  = 2'd0;
      sel_oh   = '0;
      sel_len  = '0;
      sel_freq = '0;
      any_pend = |pending_q;
      for (int i = int'(N_SFX) - 1; i >= 0; i--) begin
         if (pending_q[i]) begin
            sel_idx    = 2'(i);
            sel_oh     = '0;
            sel_oh[i]  = 1'b1;
            sel_len    = sfx.sfx_len[i*LEN_W +: LEN_W];
            sel_freq   = sfx.sfx_freq[i*FREQ_W +: FREQ_W];
         end
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state, grant/preemption, effect timing and next output values.
   always_comb begin
      state_d     = state_q;
      pending_d   = pending_q;
      dur_d       = dur_q;
      gap_d       = gap_q;
      play_freq_d = play_freq_q;
      ack_d       = '0;
      id_d        = active_id;
      grant       = 1'b0;
      freq_l_d    = SILENCE;
      freq_r_d    = SILENCE;

      unique case (state_q)
         IDLE: begin
            grant = any_pend;
         end
         PLAY: begin
            if (any_pend && (sel_idx < active_id)) begin
               grant = 1'b1;
            end else if (tick) begin
               if (dur_q <= LEN_W'(1)) begin
                  if (GAP_TICKS > 0) begin
                     state_d = GAP;
                     gap_d   = GAP_W'(GAP_TICKS);
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  dur_d = dur_q - LEN_W'(1);
               end
            end
         end
         GAP: begin
            if (tick) begin
               if (gap_q <= GAP_W'(1)) begin
                  state_d = IDLE;
               end else begin
                  gap_d = gap_q - GAP_W'(1);
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // A zero-length effect is acknowledged and discarded without playing.
      if (grant) begin
         pending_d = pending_q & ~sel_oh;
         ack_d     = sel_oh;
         id_d      = sel_idx;
         if (sel_len == '0) begin
            state_d = IDLE;
         end else begin
            state_d     = PLAY;
            dur_d       = sel_len;
            play_freq_d = sel_freq;
         end
      end

      // New requests merge in last so a same-cycle retrigger survives its own grant.
      pending_d = pending_d | sfx.sfx_req;

      if (!mute) begin
         unique case (state_d)
            PLAY: begin
               freq_l_d = play_freq_d;
               freq_r_d = play_freq_d;
            end
            GAP: begin
               freq_l_d = SILENCE;
               freq_r_d = SILENCE;
            end
            default: begin
               freq_l_d = bgm_freqL;
               freq_r_d = bgm_freqR;
            end
         endcase
      end
   end

   // Datapath and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         pending_q   <= '0;
         dur_q       <= '0;
         gap_q       <= '0;
         play_freq_q <= SILENCE;
         sfx.sfx_ack <= '0;
         active_id   <= 2'd0;
         sfx_busy    <= 1'b0;
         freqL       <= SILENCE;
         freqR       <= SILENCE;
      end else begin
         pending_q   <= pending_d;
         dur_q       <= dur_d;
         gap_q       <= gap_d;
         play_freq_q <= play_freq_d;
         sfx.sfx_ack <= ack_d;
         active_id   <= id_d;
         sfx_busy    <= (state_d == PLAY);
         freqL       <= freq_l_d;
         freqR       <= freq_r_d;
      end
   end

endmodule
